mac_operand_sequencer: RTL and testbench
========================================

// Module: mac_operand_sequencer
// PURPOSE
//  Upstream feeder for the 4x4 Vedic MAC stage. Buffers incoming 4-bit operand
//  pairs in a small FIFO (valid/ready on the input side). On a start pulse it
//  clears the MAC accumulator, then streams cfg_len pairs into the MAC, one per
//  cycle. When the accumulator holds the complete dot product, it pulses done.
// PARAMETERS
//  DEPTH   4  FIFO entries; power of two, 2..8
//  AW      2  FIFO pointer width; equals log2(DEPTH)
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     synchronous reset, active-high
//  in_valid   in   1     operand pair on in_a/in_b is valid
//  in_a       in   4     multiplicand
//  in_b       in   4     multiplier
//  in_ready   out  1     FIFO can accept a pair; equals !full
//  start      in   1     single-cycle request to begin a dot product
//  cfg_len    in   4     number of terms; sampled on an accepted start; 0 is treated as 1
//  busy       out  1     high in every state except IDLE
//  mac_a      out  4     operand a to the MAC; 0 when no term is issued
//  mac_b      out  4     operand b to the MAC; 0 when no term is issued
//  mac_clr    out  1     accumulator clear; high for exactly one cycle
//  done       out  1     one-cycle pulse; MAC output C is final in this cycle
//  level      out  AW+1  FIFO occupancy, 0..DEPTH
//  ovf        out  1     sticky overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: applies at the clock edge while rst=1.
//   - FIFO is emptied and state goes to IDLE.
//   - level=0, in_ready=1; busy, mac_clr, done and ovf are 0; mac_a=mac_b=0.
//   - Reset in the middle of an operation abandons it. No done is produced.
//  FIFO:
//   - Push when in_valid && in_ready. Pop when RUN issues a term.
//   - A push and a pop in the same cycle leave level unchanged.
//   - There is no full-bypass. When full, in_ready=0 even if a pop happens in that cycle.
//   - Pointers wrap modulo DEPTH. Data is returned in push order.
//  FSM states are IDLE, CLR, RUN and FLUSH.
//   - IDLE: start=1 latches remaining=max(cfg_len,1) and moves to CLR.
//   - start is ignored in every state other than IDLE.
//   - CLR lasts one cycle. mac_clr=1 and operands are 0. Next state is RUN.
//   - RUN, FIFO non-empty: pop the head pair and drive it on mac_a/mac_b; remaining--.
//   - RUN, FIFO empty: stall with operands at 0. This adds 0 to the accumulator, which is harmless.
//   - RUN: when the last term is issued (remaining==1 at the pop), go to FLUSH.
//   - FLUSH lasts one cycle. done=1 and operands are 0. Next state is IDLE.
//   - The MAC registers its sum one cycle after a term, so C is valid while done=1.
//  Latency: with data already in the FIFO, done asserts N+2 cycles after start is accepted.
//  Outputs mac_a, mac_b, mac_clr and done are combinational decodes of state and FIFO head.
// CONFIGURATION
//  SEQ_OVF_FLAG_EN defined:
//   - A 9-bit shadow sum is cleared in CLR.
//   - Each issued a*b is added to it.
//   - If bit 8 ever sets, ovf is set and stays 1 until the next accepted start or rst.
//   - This flags wrap-around of the downstream 8-bit accumulator.
//  SEQ_OVF_FLAG_EN undefined: ovf is tied to 0 and no shadow logic is built.
// TESTING
//  T1: push (3,5),(2,7); start with cfg_len=2.
//      -> mac_clr in cycle 1, terms in cycles 2-3, done in cycle 4, C=29, ovf=0.
//  T2: push 5 pairs with DEPTH=4 and no start.
//      -> in_ready=0 after the 4th push; 5th pair not accepted; level=4.
//  T3: start with cfg_len=3 and the FIFO empty; push one pair every 3 cycles, (1,1) three times.
//      -> RUN stalls between pushes; done once; C=3.
//  T4: with the macro defined, push (15,15),(15,15); start with cfg_len=2.
//      -> C=194 (450 mod 256); ovf=1; ovf clears on the next start.
//  T5: cfg_len=0 with one pair (4,4).
//      -> treated as 1; done; C=16; FIFO left empty.
//  T6: assert rst in the middle of RUN.
//      -> next cycle IDLE, level=0, no done; a following start works normally.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
// Operand feeder for the 4x4 Vedic MAC: FIFO-buffered pairs, clear/run/flush sequencing.
// Optional sticky accumulator-overflow flag enabled by defining SEQ_OVF_FLAG_EN.
module mac_operand_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_in_valid,
  input  logic [3:0]    i_in_a,
  input  logic [3:0]    i_in_b,
  output logic          o_in_ready,
  input  logic          i_start,
  input  logic [3:0]    i_cfg_len,
  output logic          o_busy,
  output logic [3:0]    o_mac_a,
  output logic [3:0]    o_mac_b,
  output logic          o_mac_clr,
  output logic          o_done,
  output logic [AW:0]   o_level,
  output logic          o_ovf
);

  typedef enum logic [1:0] {StIdle, StClr, StRun, StFlush} state_e;

  localparam logic [AW:0] LvlFull = (AW + 1)'(DEPTH);

  state_e      r_state, w_state_next;
  logic [3:0]  r_mem_a [DEPTH];
  logic [3:0]  r_mem_b [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic [3:0]  r_remaining;
  logic        w_full, w_empty, w_push, w_pop, w_start_ok;

  assign w_full     = (r_count == LvlFull);
  assign w_empty    = (r_count == '0);
  assign w_push     = i_in_valid && !w_full;
  assign w_pop      = (r_state == StRun) && !w_empty;
  assign w_start_ok = (r_state == StIdle) && i_start;
  assign o_in_ready = !w_full;
  assign o_level    = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_a[r_wptr] <= i_in_a;
      r_mem_b[r_wptr] <= i_in_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // State register plus term counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_remaining <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_ok) begin
        r_remaining <= (i_cfg_len == '0) ? 4'd1 : i_cfg_len;
      end else if (w_pop) begin
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StClr;
      StClr:   w_state_next = StRun;
      StRun:   if (w_pop && (r_remaining == 4'd1)) w_state_next = StFlush;
      StFlush: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_busy    = (r_state != StIdle);
    o_mac_a   = '0;
    o_mac_b   = '0;
    o_mac_clr = 1'b0;
    o_done    = 1'b0;
    unique case (r_state)
      StClr:   o_mac_clr = 1'b1;
      StRun: begin
        if (w_pop) begin
          o_mac_a = r_mem_a[r_rptr];
          o_mac_b = r_mem_b[r_rptr];
        end
      end
      StFlush: o_done = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_OVF_FLAG_EN
  // Shadow of the downstream accumulator with one extra bit to catch 8-bit wrap.
  logic [8:0] r_shadow;
  logic       r_ovf;
  logic [7:0] w_prod;
  logic [8:0] w_shadow_sum;

  assign w_prod       = {4'b0, o_mac_a} * {4'b0, o_mac_b};
  assign w_shadow_sum = r_shadow + {1'b0, w_prod};
  assign o_ovf        = r_ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_start_ok) r_ovf <= 1'b0;
      if (r_state == StClr) begin
        r_shadow <= '0;
      end else if (w_pop) begin
        r_shadow <= w_shadow_sum;
        if (w_shadow_sum[8]) r_ovf <= 1'b1;
      end
    end
  end
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Scoreboard bench for mac_operand_sequencer with a behavioural 8-bit MAC downstream.
module tb_mac_operand_sequencer;

`ifdef SEQ_OVF_FLAG_EN
  localparam logic OvfEn = 1'b1;
`else
  localparam logic OvfEn = 1'b0;
`endif

  logic       clk, rst;
  logic       in_valid, in_ready, start, busy, mac_clr, done, ovf;
  logic [3:0] in_a, in_b, cfg_len, mac_a, mac_b;
  logic [2:0] level;

  mac_operand_sequencer #(.DEPTH(4), .AW(2)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_valid (in_valid),
    .i_in_a     (in_a),
    .i_in_b     (in_b),
    .o_in_ready (in_ready),
    .i_start    (start),
    .i_cfg_len  (cfg_len),
    .o_busy     (busy),
    .o_mac_a    (mac_a),
    .o_mac_b    (mac_b),
    .o_mac_clr  (mac_clr),
    .o_done     (done),
    .o_level    (level),
    .o_ovf      (ovf)
  );

  typedef struct {
    logic [7:0] c;
    logic       ovf;
    int         start_cyc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [7:0] acc = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare on done, then advance the downstream MAC model.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("mac_c", int'(acc), int'(e.c));
          check("ovf_at_done", int'(ovf), int'(e.ovf));
          if (e.lat >= 0) check("done_latency", cyc - e.start_cyc, e.lat);
        end
      end
      if (mac_clr) acc = '0;
      else acc = acc + 8'({4'b0, mac_a} * {4'b0, mac_b});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] len, input bit track, input logic [7:0] c,
                          input logic o, input int lat);
    exp_t e;
    e.c = c;
    e.ovf = o;
    e.start_cyc = cyc;
    e.lat = lat;
    if (track) sb.push_back(e);
    start   = 1'b1;
    cfg_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", n >= 200 ? 1 : 0, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; start = 1'b0; cfg_len = '0;
    tick();
    tick();
    check("rst_level", int'(level), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mac_clr", int'(mac_clr), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_mac_ab", int'({mac_a, mac_b}), 0);
    rst = 1'b0;
    tick();

    // T1: 3*5 + 2*7 = 29, done four cycles after start.
    push(4'd3, 4'd5);
    push(4'd2, 4'd7);
    check("t1_level", int'(level), 2);
    do_start(4'd2, 1'b1, 8'd29, 1'b0, 4);
    check("t1_clr", int'(mac_clr), 1);
    wait_idle();

    // T2: fill to full, fifth push refused; then drain 2+12+30+56 = 100.
    push(4'd1, 4'd2);
    push(4'd3, 4'd4);
    push(4'd5, 4'd6);
    check("t2_ready_3", int'(in_ready), 1);
    push(4'd7, 4'd8);
    check("t2_ready_full", int'(in_ready), 0);
    check("t2_level_full", int'(level), 4);
    push(4'd9, 4'd9);
    check("t2_level_after5", int'(level), 4);
    do_start(4'd4, 1'b1, 8'd100, 1'b0, 6);
    wait_idle();
    check("t2_level_drained", int'(level), 0);

    // T3: start on empty FIFO, trickle (1,1) three times.
    do_start(4'd3, 1'b1, 8'd3, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
      check("t3_busy", int'(busy), 1);
      push(4'd1, 4'd1);
    end
    wait_idle();

    // T4: 225 + 225 = 450 -> 194 with overflow (flag only in that build).
    push(4'd15, 4'd15);
    push(4'd15, 4'd15);
    do_start(4'd2, 1'b1, 8'd194, OvfEn, 4);
    wait_idle();
    check("t4_ovf_sticky", int'(ovf), int'(OvfEn));

    // T5: cfg_len 0 acts as 1; start also clears ovf.
    push(4'd4, 4'd4);
    do_start(4'd0, 1'b1, 8'd16, 1'b0, 3);
    check("t5_ovf_cleared", int'(ovf), 0);
    wait_idle();
    check("t5_level", int'(level), 0);

    // T6: reset during RUN abandons the operation.
    push(4'd2, 4'd2);
    push(4'd2, 4'd2);
    push(4'd2, 4'd2);
    do_start(4'd3, 1'b0, 8'd0, 1'b0, -1);
    tick();
    check("t6_in_run", int'(mac_a), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", int'(busy), 0);
    check("t6_level", int'(level), 0);
    check("t6_done", int'(done), 0);
    repeat (4) tick();
    push(4'd6, 4'd7);
    do_start(4'd1, 1'b1, 8'd42, 1'b0, 3);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
